// File: rtl/bp_profiler_drain_pkg.sv
// Shared types and constants for the profiler counter-bank drain.
// The state enum is exported so observers can decode the FSM debug port.
package bp_profiler_drain_pkg;

   typedef enum logic [1:0] {
      e_idle   = 2'd0,
      e_header = 2'd1,
      e_data   = 2'd2
   } state_e;

   // Width of the element-count field in the top bits of the header word.
   localparam int hdr_field_w = 16;

   // clog2 that never returns zero, so a one-entry bank still gets a 1-bit index.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bp_profiler_drain_if.sv
// Snapshot-request and output-stream signals of the drain block.
// Both channels are valid/ready: a transfer happens on a clock edge where valid and ready are both high;
// the producer keeps valid and data stable until that edge and never withdraws valid without a transfer.
interface bp_profiler_drain_if #(
   parameter int width_p = 32
) ();

   logic               snap_v;
   logic               snap_ready_and;
   logic [width_p-1:0] data;
   logic               v;
   logic               ready_and;

   modport master (
      input  snap_v,
      output snap_ready_and,
      output data,
      output v,
      input  ready_and
   );

   modport slave (
      output snap_v,
      input  snap_ready_and,
      input  data,
      input  v,
      output ready_and
   );

endinterface

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous reset and a clear that wins over the increment.
module bsg_counter_clear_up #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               up_i,
   output logic [width_p-1:0] count_o
);

   logic [width_p-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)   count_d = width_p'(up_i);
      else if (up_i) count_d = count_q + width_p'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/bsg_dff_en.sv
// Enable-gated register with no reset, used for the counter snapshot.
module bsg_dff_en #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               en_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   logic [width_p-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (en_i) data_q <= data_i;
   end

   assign data_o = data_q;

endmodule

// File: rtl/bsg_mux.sv
// Word selector over a packed array of equal-width inputs.
module bsg_mux #(
   parameter int width_p  = 1,
   parameter int els_p    = 1,
   parameter int lg_els_p = 1
) (
   input  logic [els_p-1:0][width_p-1:0] data_i,
   input  logic [lg_els_p-1:0]           sel_i,
   output logic [width_p-1:0]            data_o
);

   assign data_o = data_i[sel_i];

endmodule

// File: rtl/bp_profiler_drain.sv
// Atomically snapshots the profiler counter bank on request, then streams a header word
// followed by every counter in index order, one word per accepted beat.
module bp_profiler_drain
   import bp_profiler_drain_pkg::*;
#(
   parameter int els_p           = 65,
   parameter int width_p         = 32,
   parameter int clear_on_read_p = 0
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [els_p-1:0][width_p-1:0] counters_i,
   bp_profiler_drain_if.master           io,
   output logic                          clear_o,
   output logic                          busy_o,
   output logic [width_p-1:0]            seq_o,
   output state_e                        state_o
);

   localparam int                     idx_w     = safe_clog2(els_p);
   localparam logic [idx_w-1:0]       last_idx  = idx_w'(els_p - 1);
   localparam logic [hdr_field_w-1:0] els_field = hdr_field_w'(els_p);
   localparam logic [width_p-1:0]     low_mask  = {width_p{1'b1}} >> hdr_field_w;
   localparam logic [width_p-1:0]     hdr_count = width_p'(els_field) << (width_p - hdr_field_w);
   localparam logic                   clear_en  = (clear_on_read_p != 0);

   state_e                        state_q, state_d;
   logic [width_p-1:0]            seq_q, seq_d;
   logic [idx_w-1:0]              idx_r;
   logic [els_p-1:0][width_p-1:0] snap_r;
   logic [width_p-1:0]            snap_word;
   logic [width_p-1:0]            hdr_word;
   logic [width_p-1:0]            data_d;
   logic                          capture;
   logic                          idx_up;
   logic                          idx_clear;
   logic                          snap_ready;
   logic                          v_d;
   logic                          busy_d;

   bsg_dff_en #(
      .width_p(els_p * width_p)
   ) snap_reg (
      .clk_i (clk_i),
      .en_i  (capture),
      .data_i(counters_i),
      .data_o(snap_r)
   );

   bsg_counter_clear_up #(
      .width_p(idx_w)
   ) idx_ctr (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .clear_i(idx_clear),
      .up_i   (idx_up),
      .count_o(idx_r)
   );

   bsg_mux #(
      .width_p (width_p),
      .els_p   (els_p),
      .lg_els_p(idx_w)
   ) word_mux (
      .data_i(snap_r),
      .sel_i (idx_r),
      .data_o(snap_word)
   );

   // Header: element count in the top 16 bits, low bits of the drain sequence below it.
   assign hdr_word = hdr_count | (seq_q & low_mask);

   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      capture    = 1'b0;
      idx_up     = 1'b0;
      idx_clear  = 1'b0;
      snap_ready = 1'b0;
      v_d        = 1'b0;
      busy_d     = 1'b0;
      data_d     = hdr_word;
      unique case (state_q)
         e_idle: begin
            snap_ready = 1'b1;
            if (io.snap_v) begin
               capture = 1'b1;
               state_d = e_header;
            end
         end
         e_header: begin
            v_d    = 1'b1;
            busy_d = 1'b1;
            if (io.ready_and) state_d = e_data;
         end
         e_data: begin
            v_d    = 1'b1;
            busy_d = 1'b1;
            data_d = snap_word;
            if (io.ready_and) begin
               if (idx_r == last_idx) begin
                  idx_clear = 1'b1;
                  seq_d     = seq_q + width_p'(1);
                  state_d   = e_idle;
               end else begin
                  idx_up = 1'b1;
               end
            end
         end
         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= e_idle;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
      end
   end

   // Clear rides the capture edge so the snapshot holds the pre-clear values.
   assign clear_o           = clear_en & capture;
   assign io.snap_ready_and = snap_ready;
   assign io.v              = v_d;
   assign io.data           = data_d;
   assign busy_o            = busy_d;
   assign seq_o             = seq_q;
   assign state_o           = state_q;

endmodule
